block_move_ctrl: RTL and testbench

//   Sequential successor to the combinational test-position generator. Holds the active piece's

---
 rtl/block_move_ctrl_pkg.sv | 36 +++
 rtl/block_move_ctrl_if.sv | 25 ++
 rtl/block_move_ctrl_kick_offset.sv | 27 ++
 rtl/block_move_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_block_move_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/block_move_ctrl_pkg.sv
// Shared types for the block move controller: FSM states, request kinds and
// the rotation wall-kick offset table.
package block_move_ctrl_pkg;

  localparam int KICK_IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TEST,
    ST_DROP
  } state_t;

  typedef enum logic [1:0] {
    OP_FALL,
    OP_LEFT,
    OP_RIGHT,
    OP_ROT
  } op_t;

  // Kick order alternates around the committed column: 0, +1, -1, +2, -2, ...
  function automatic logic signed [3:0] kickOffset(input logic [KICK_IDX_W-1:0] idx);
    logic signed [3:0] off;
    case (idx)
      3'd0:    off = 4'sd0;
      3'd1:    off = 4'sd1;
      3'd2:    off = -4'sd1;
      3'd3:    off = 4'sd2;
      3'd4:    off = -4'sd2;
      3'd5:    off = 4'sd3;
      3'd6:    off = -4'sd3;
      default: off = 4'sd4;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/block_move_ctrl_if.sv
// Candidate/result handshake between the move controller and the collision checker.
interface block_move_ctrl_if #(
  parameter int BITS_X   = 4,
  parameter int BITS_Y   = 5,
  parameter int BITS_ROT = 2
);

  logic                chk_req;
  logic [BITS_X-1:0]   chk_x;
  logic [BITS_Y-1:0]   chk_y;
  logic [BITS_ROT-1:0] chk_rot;
  logic                chk_ack;
  logic                chk_fit;

  modport master (
    output chk_req, chk_x, chk_y, chk_rot,
    input  chk_ack, chk_fit
  );

  modport slave (
    input  chk_req, chk_x, chk_y, chk_rot,
    output chk_ack, chk_fit
  );

endinterface

// File: rtl/block_move_ctrl_kick_offset.sv
// Applies a kick-table x offset to a base column and flags results that fall
// off either edge of the x range.
module block_move_ctrl_kick_offset
  import block_move_ctrl_pkg::*;
#(
  parameter int BITS_X = 4
) (
  input  logic [BITS_X-1:0]     baseX_i,
  input  logic [KICK_IDX_W-1:0] kickIdx_i,
  output logic [BITS_X-1:0]     candX_o,
  output logic                  wrap_o
);

  logic signed [3:0]        offset;
  logic signed [BITS_X+1:0] offsetExt;
  logic signed [BITS_X+1:0] sum;

  // Two guard bits: the top one catches underflow, the next catches overflow.
  always_comb begin
    offset    = kickOffset(kickIdx_i);
    offsetExt = (BITS_X+2)'(offset);
    sum       = $signed({2'b00, baseX_i}) + offsetExt;
    candX_o   = sum[BITS_X-1:0];
    wrap_o    = sum[BITS_X+1] | sum[BITS_X];
  end

endmodule

// File: rtl/block_move_ctrl.sv
// Active-piece move controller: turns move requests into candidate positions,
// handshakes each with the collision checker, then commits or rejects it.
module block_move_ctrl
  import block_move_ctrl_pkg::*;
#(
  parameter int BITS_X    = 4,
  parameter int BITS_Y    = 5,
  parameter int BITS_ROT  = 2,
  parameter int NUM_KICKS = 3,
  parameter int SPAWN_X   = 3,
  parameter int SPAWN_Y   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                spawn_i,
  input  logic                fall_en_i,
  input  logic                down_en_i,
  input  logic                left_en_i,
  input  logic                right_en_i,
  input  logic                rotate_en_i,
  input  logic                drop_en_i,
  block_move_ctrl_if.master   chk,
  output logic [BITS_X-1:0]   cur_x_o,
  output logic [BITS_Y-1:0]   cur_y_o,
  output logic [BITS_ROT-1:0] cur_rot_o,
  output logic                busy_o,
  output logic                move_done_o,
  output logic                lock_o
);

  localparam logic [BITS_X-1:0]     SPAWN_XV  = BITS_X'(SPAWN_X);
  localparam logic [BITS_Y-1:0]     SPAWN_YV  = BITS_Y'(SPAWN_Y);
  localparam logic [KICK_IDX_W-1:0] LAST_KICK = KICK_IDX_W'(NUM_KICKS - 1);

  state_t                  state_q,    state_d;
  op_t                     op_q,       op_d;
  logic [KICK_IDX_W-1:0]   kickIdx_q,  kickIdx_d;
  logic [BITS_X-1:0]       curX_q,     curX_d;
  logic [BITS_Y-1:0]       curY_q,     curY_d;
  logic [BITS_ROT-1:0]     curRot_q,   curRot_d;
  logic [BITS_X-1:0]       candX_q,    candX_d;
  logic [BITS_Y-1:0]       candY_q,    candY_d;
  logic [BITS_ROT-1:0]     candRot_q,  candRot_d;
  logic                    candWrap_q, candWrap_d;
  logic                    moveDone_q, moveDone_d;
  logic                    lock_q,     lock_d;

  logic [KICK_IDX_W-1:0]   kickSel;
  logic [BITS_X-1:0]       kickX;
  logic                    kickWrap;
  logic                    checkDone;
  logic                    checkFit;

  // Left and right reuse the kick table (+1 is entry 1, -1 is entry 2) so all
  // horizontal edge detection lives in one place.
  always_comb begin
    kickSel = '0;
    if (state_q == ST_IDLE) begin
      if (left_en_i)       kickSel = KICK_IDX_W'(2);
      else if (right_en_i) kickSel = KICK_IDX_W'(1);
    end else begin
      kickSel = kickIdx_q + KICK_IDX_W'(1);
    end
  end

  block_move_ctrl_kick_offset #(
    .BITS_X(BITS_X)
  ) u_kick (
    .baseX_i   (curX_q),
    .kickIdx_i (kickSel),
    .candX_o   (kickX),
    .wrap_o    (kickWrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_FALL;
      kickIdx_q  <= '0;
      curX_q     <= SPAWN_XV;
      curY_q     <= SPAWN_YV;
      curRot_q   <= '0;
      candX_q    <= SPAWN_XV;
      candY_q    <= SPAWN_YV;
      candRot_q  <= '0;
      candWrap_q <= 1'b0;
      moveDone_q <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      kickIdx_q  <= kickIdx_d;
      curX_q     <= curX_d;
      curY_q     <= curY_d;
      curRot_q   <= curRot_d;
      candX_q    <= candX_d;
      candY_q    <= candY_d;
      candRot_q  <= candRot_d;
      candWrap_q <= candWrap_d;
      moveDone_q <= moveDone_d;
      lock_q     <= lock_d;
    end
  end

  // A wrapped candidate never reaches the checker; it resolves as a misfit
  // in the same cycle it would otherwise have been presented.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    kickIdx_d  = kickIdx_q;
    curX_d     = curX_q;
    curY_d     = curY_q;
    curRot_d   = curRot_q;
    candX_d    = candX_q;
    candY_d    = candY_q;
    candRot_d  = candRot_q;
    candWrap_d = candWrap_q;
    moveDone_d = 1'b0;
    lock_d     = 1'b0;
    checkDone  = (state_q != ST_IDLE) && (candWrap_q || chk.chk_ack);
    checkFit   = !candWrap_q && chk.chk_fit;

    case (state_q)
      ST_IDLE: begin
        candX_d    = curX_q;
        candY_d    = curY_q;
        candRot_d  = curRot_q;
        candWrap_d = 1'b0;
        kickIdx_d  = '0;
        if (fall_en_i || down_en_i) begin
          op_d       = OP_FALL;
          candY_d    = curY_q + 1'b1;
          candWrap_d = &curY_q;
          state_d    = ST_TEST;
        end else if (left_en_i || right_en_i) begin
          op_d       = left_en_i ? OP_LEFT : OP_RIGHT;
          candX_d    = kickX;
          candWrap_d = kickWrap;
          state_d    = ST_TEST;
        end else if (rotate_en_i) begin
          op_d       = OP_ROT;
          candX_d    = kickX;
          candWrap_d = kickWrap;
          candRot_d  = curRot_q + 1'b1;
          state_d    = ST_TEST;
        end else if (drop_en_i) begin
          candY_d    = curY_q + 1'b1;
          candWrap_d = &curY_q;
          state_d    = ST_DROP;
        end
      end

      ST_TEST: begin
        if (checkDone) begin
          if (checkFit) begin
            curX_d     = candX_q;
            curY_d     = candY_q;
            curRot_d   = candRot_q;
            moveDone_d = 1'b1;
            state_d    = ST_IDLE;
          end else if (op_q == OP_ROT && kickIdx_q != LAST_KICK) begin
            kickIdx_d  = kickIdx_q + 1'b1;
            candX_d    = kickX;
            candWrap_d = kickWrap;
          end else begin
            moveDone_d = 1'b1;
            lock_d     = (op_q == OP_FALL);
            state_d    = ST_IDLE;
          end
        end
      end

      ST_DROP: begin
        if (checkDone) begin
          if (checkFit) begin
            curY_d     = candY_q;
            candY_d    = candY_q + 1'b1;
            candWrap_d = &candY_q;
          end else begin
            moveDone_d = 1'b1;
            lock_d     = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (spawn_i) begin
      state_d    = ST_IDLE;
      kickIdx_d  = '0;
      curX_d     = SPAWN_XV;
      curY_d     = SPAWN_YV;
      curRot_d   = '0;
      candX_d    = SPAWN_XV;
      candY_d    = SPAWN_YV;
      candRot_d  = '0;
      candWrap_d = 1'b0;
      moveDone_d = 1'b0;
      lock_d     = 1'b0;
    end
  end

  assign chk.chk_req  = (state_q != ST_IDLE) && !candWrap_q;
  assign chk.chk_x    = (state_q == ST_IDLE) ? curX_q   : candX_q;
  assign chk.chk_y    = (state_q == ST_IDLE) ? curY_q   : candY_q;
  assign chk.chk_rot  = (state_q == ST_IDLE) ? curRot_q : candRot_q;

  assign cur_x_o      = curX_q;
  assign cur_y_o      = curY_q;
  assign cur_rot_o    = curRot_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign move_done_o  = moveDone_q;
  assign lock_o       = lock_q;

endmodule

// File: tb/tb_block_move_ctrl.sv
// Directed bench for block_move_ctrl: the bench plays the collision checker
// and compares outputs against hand-computed positions and pulses.
module tb_block_move_ctrl;

  localparam logic [6:0] REQ_SPAWN = 7'b1000000;
  localparam logic [6:0] REQ_FALL  = 7'b0100000;
  localparam logic [6:0] REQ_LEFT  = 7'b0001000;
  localparam logic [6:0] REQ_RIGHT = 7'b0000100;
  localparam logic [6:0] REQ_ROT   = 7'b0000010;
  localparam logic [6:0] REQ_DROP  = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spawn, fallEn, downEn, leftEn, rightEn, rotateEn, dropEn;
  logic [3:0] curX;
  logic [4:0] curY;
  logic [1:0] curRot;
  logic       busy, moveDone, lock;

  int nCompared   = 0;
  int nMismatched = 0;
  int hsCount     = 0;
  int hsStart;

  block_move_ctrl_if #(.BITS_X(4), .BITS_Y(5), .BITS_ROT(2)) chkIf ();

  block_move_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spawn_i     (spawn),
    .fall_en_i   (fallEn),
    .down_en_i   (downEn),
    .left_en_i   (leftEn),
    .right_en_i  (rightEn),
    .rotate_en_i (rotateEn),
    .drop_en_i   (dropEn),
    .chk         (chkIf),
    .cur_x_o     (curX),
    .cur_y_o     (curY),
    .cur_rot_o   (curRot),
    .busy_o      (busy),
    .move_done_o (moveDone),
    .lock_o      (lock)
  );

  always #5 clk = ~clk;

  // Counts completed checker handshakes as the DUT sees them.
  always @(posedge clk) begin
    if (chkIf.chk_req && chkIf.chk_ack) hsCount <= hsCount + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] req);
    {spawn, fallEn, downEn, leftEn, rightEn, rotateEn, dropEn} = req;
    tick();
    {spawn, fallEn, downEn, leftEn, rightEn, rotateEn, dropEn} = '0;
  endtask

  // Waits (bounded) for chk_req, checks the candidate, then answers it.
  task automatic serviceCheck(input logic fit, input int ex, input int ey, input int erot, input string tag);
    int waitCnt = 0;
    while (chkIf.chk_req !== 1'b1 && waitCnt < 10) begin
      tick();
      waitCnt++;
    end
    checkOutput({tag, "_req"}, {31'd0, chkIf.chk_req}, 32'd1);
    checkOutput({tag, "_x"},   {28'd0, chkIf.chk_x},   ex);
    checkOutput({tag, "_y"},   {27'd0, chkIf.chk_y},   ey);
    checkOutput({tag, "_rot"}, {30'd0, chkIf.chk_rot}, erot);
    chkIf.chk_ack = 1'b1;
    chkIf.chk_fit = fit;
    tick();
    chkIf.chk_ack = 1'b0;
    chkIf.chk_fit = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    {spawn, fallEn, downEn, leftEn, rightEn, rotateEn, dropEn} = '0;
    chkIf.chk_ack = 1'b0;
    chkIf.chk_fit = 1'b0;
    tick();
    tick();
    checkOutput("rst_busy",  busy, 0);
    checkOutput("rst_x",     curX, 3);
    checkOutput("rst_y",     curY, 0);
    checkOutput("rst_rot",   curRot, 0);
    checkOutput("rst_req",   chkIf.chk_req, 0);
    checkOutput("rst_chkx",  chkIf.chk_x, 3);
    checkOutput("rst_done",  moveDone, 0);
    checkOutput("rst_lock",  lock, 0);
    rst_n = 1'b1;
    tick();

    // Left from x=3 with ack+fit in the first request cycle.
    applyStimulus(REQ_LEFT);
    serviceCheck(1'b1, 2, 0, 0, "left");
    checkOutput("left_curx", curX, 2);
    checkOutput("left_done", moveDone, 1);
    checkOutput("left_busy", busy, 0);
    tick();
    checkOutput("left_done_end", moveDone, 0);

    // Walk rotation to 3, then rotate with a failing first kick.
    for (int r = 1; r <= 3; r++) begin
      applyStimulus(REQ_ROT);
      serviceCheck(1'b1, 2, 0, r % 4, "rot_pre");
      tick();
    end
    checkOutput("rot_pre_rot", curRot, 3);
    applyStimulus(REQ_ROT);
    serviceCheck(1'b0, 2, 0, 0, "rot_k0");
    checkOutput("rot_k0_done", moveDone, 0);
    checkOutput("rot_k0_busy", busy, 1);
    serviceCheck(1'b1, 3, 0, 0, "rot_k1");
    checkOutput("rot_curx", curX, 3);
    checkOutput("rot_currot", curRot, 0);
    checkOutput("rot_done", moveDone, 1);
    tick();
    checkOutput("rot_done_end", moveDone, 0);

    // Hard drop from y=0: fits through y=6, fails at y=7.
    hsStart = hsCount;
    applyStimulus(REQ_DROP);
    for (int y = 1; y <= 6; y++) begin
      serviceCheck(1'b1, 3, y, 0, "drop_step");
      checkOutput("drop_step_lock", lock, 0);
    end
    serviceCheck(1'b0, 3, 7, 0, "drop_last");
    checkOutput("drop_cury", curY, 6);
    checkOutput("drop_lock", lock, 1);
    checkOutput("drop_done", moveDone, 1);
    checkOutput("drop_checks", hsCount - hsStart, 7);
    tick();
    checkOutput("drop_lock_end", lock, 0);
    checkOutput("drop_busy_end", busy, 0);

    // Respawn, walk to x=0, then try to move past the left wall.
    applyStimulus(REQ_SPAWN);
    checkOutput("spawn_y", curY, 0);
    checkOutput("spawn_done", moveDone, 0);
    for (int x = 2; x >= 0; x--) begin
      applyStimulus(REQ_LEFT);
      serviceCheck(1'b1, x, 0, 0, "walk");
      tick();
    end
    checkOutput("walk_x", curX, 0);
    applyStimulus(REQ_LEFT);
    checkOutput("wrap_req", chkIf.chk_req, 0);
    checkOutput("wrap_busy", busy, 1);
    tick();
    checkOutput("wrap_done", moveDone, 1);
    checkOutput("wrap_lock", lock, 0);
    checkOutput("wrap_curx", curX, 0);
    checkOutput("wrap_busy_end", busy, 0);
    tick();

    // Gravity tick that does not fit locks the piece.
    applyStimulus(REQ_FALL);
    serviceCheck(1'b0, 0, 1, 0, "fall");
    checkOutput("fall_lock", lock, 1);
    checkOutput("fall_done", moveDone, 1);
    checkOutput("fall_cury", curY, 0);
    tick();

    // Asynchronous reset in the middle of a hard drop at y=4.
    applyStimulus(REQ_DROP);
    for (int y = 1; y <= 4; y++) serviceCheck(1'b1, 0, y, 0, "rdrop");
    checkOutput("rdrop_cury", curY, 4);
    checkOutput("rdrop_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_req",  chkIf.chk_req, 0);
    checkOutput("arst_x",    curX, 3);
    checkOutput("arst_y",    curY, 0);
    checkOutput("arst_rot",  curRot, 0);
    checkOutput("arst_done", moveDone, 0);
    checkOutput("arst_lock", lock, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Spawn beats a simultaneous left; a left while busy is dropped.
    applyStimulus(REQ_RIGHT);
    serviceCheck(1'b1, 4, 0, 0, "right");
    checkOutput("right_curx", curX, 4);
    tick();
    applyStimulus(REQ_SPAWN | REQ_LEFT);
    checkOutput("prio_busy", busy, 0);
    checkOutput("prio_curx", curX, 3);
    checkOutput("prio_req",  chkIf.chk_req, 0);
    checkOutput("prio_done", moveDone, 0);
    tick();
    checkOutput("prio_busy2", busy, 0);
    applyStimulus(REQ_RIGHT);
    applyStimulus(REQ_LEFT);
    checkOutput("hold_busy", busy, 1);
    checkOutput("hold_chkx", chkIf.chk_x, 4);
    serviceCheck(1'b1, 4, 0, 0, "hold");
    checkOutput("hold_curx", curX, 4);
    checkOutput("hold_done", moveDone, 1);
    tick();
    checkOutput("ignored_busy", busy, 0);
    checkOutput("ignored_req",  chkIf.chk_req, 0);
    checkOutput("ignored_curx", curX, 4);
    checkOutput("ignored_done", moveDone, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
